// File: rtl/face_pkg.sv
// Shared definitions for the face template ROM and its compare engine.
// The image table is produced by a constant function, so the ROM contents live in one place.
package face_pkg;

    localparam int AW = 8;
    localparam int DW = 8;
    localparam int CMP_LEN = 16;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_FIN
    } cmp_state_t;

    // Reference face template: a flat 0x74 patch, then an address-scrambled ramp
    function automatic logic [31:0] face_img(input int a);
        if (a < 16) begin
            return 32'h74;
        end
        return 32'(a) ^ 32'h5A;
    endfunction

endpackage

// File: rtl/face_rom_cmp.sv
// Compare engine: streams candidate bytes against the first CMP_LEN ROM words.
// The ROM is read through its own combinational port, indexed by ptr.
module face_rom_cmp
    import face_pkg::*;
#(
    parameter int AW = face_pkg::AW,
    parameter int DW = face_pkg::DW,
    parameter int CMP_LEN = face_pkg::CMP_LEN,
    parameter int CW = $clog2(CMP_LEN + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          in_valid,
    input  logic [DW-1:0] in_byte,
    output logic [AW-1:0] rd_addr,
    input  logic [DW-1:0] rd_data,
    output logic          busy,
    output logic          done,
    output logic          match,
    output logic [CW-1:0] mismatch_cnt,
    output logic [AW-1:0] first_mis_addr
);

    localparam logic [AW-1:0] LAST_PTR = AW'(CMP_LEN - 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(CMP_LEN);

    cmp_state_t    state;
    logic [AW-1:0] ptr;
    logic          byte_bad;

    assign rd_addr  = ptr;
    assign byte_bad = (in_byte != rd_data);

    // Compare FSM; all status outputs are registered alongside the state
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= ST_IDLE;
            ptr            <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            match          <= 1'b0;
            mismatch_cnt   <= '0;
            first_mis_addr <= '0;
        end else begin
            done <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (start) begin
                        state          <= ST_RUN;
                        busy           <= 1'b1;
                        ptr            <= '0;
                        match          <= 1'b0;
                        mismatch_cnt   <= '0;
                        first_mis_addr <= '0;
                    end
                end
                ST_RUN: begin
                    if (in_valid) begin
                        if (byte_bad) begin
                            if (mismatch_cnt != CNT_MAX) begin
                                mismatch_cnt <= mismatch_cnt + 1'b1;
                            end
                            if (mismatch_cnt == '0) begin
                                first_mis_addr <= ptr;
                            end
                        end
                        if (ptr == LAST_PTR) begin
                            // match must include the byte accepted this cycle
                            state <= ST_FIN;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            match <= (mismatch_cnt == '0) && !byte_bad;
                        end else begin
                            ptr <= ptr + 1'b1;
                        end
                    end
                end
                ST_FIN: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/face_rom.sv
// Face template ROM with a combinational pixel port and a built-in compare engine.
// The array is pure combinational constants, so reset never touches the read data.
module face_rom
    import face_pkg::*;
#(
    parameter int AW = face_pkg::AW,
    parameter int DW = face_pkg::DW,
    parameter int CMP_LEN = face_pkg::CMP_LEN
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [AW-1:0]                  addr,
    output logic [DW-1:0]                  data,
    input  logic                           start,
    input  logic                           in_valid,
    input  logic [DW-1:0]                  in_byte,
    output logic                           busy,
    output logic                           done,
    output logic                           match,
    output logic [$clog2(CMP_LEN+1)-1:0]   mismatch_cnt,
    output logic [AW-1:0]                  first_mis_addr
);

    localparam int DEPTH = 2 ** AW;

    logic [DW-1:0] rom [DEPTH];
    logic [AW-1:0] cmp_addr;
    logic [DW-1:0] cmp_data;

    // Constant ROM words, one per address
    for (genvar i = 0; i < DEPTH; i++) begin : g_rom
        assign rom[i] = DW'(face_img(i));
    end

    assign data     = rom[addr];
    assign cmp_data = rom[cmp_addr];

    face_rom_cmp #(
        .AW      (AW),
        .DW      (DW),
        .CMP_LEN (CMP_LEN)
    ) u_cmp (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .in_valid       (in_valid),
        .in_byte        (in_byte),
        .rd_addr        (cmp_addr),
        .rd_data        (cmp_data),
        .busy           (busy),
        .done           (done),
        .match          (match),
        .mismatch_cnt   (mismatch_cnt),
        .first_mis_addr (first_mis_addr)
    );

endmodule

// File: tb/tb_face_rom.sv
// Directed bench for face_rom: ROM table sweep plus compare runs.
// Inputs change on the falling edge; outputs are sampled there too.
module tb_face_rom;

    logic       clk = 1'b0;
    logic       clk_en = 1'b0;
    logic       rst;
    logic [7:0] addr;
    logic [7:0] data;
    logic       start;
    logic       in_valid;
    logic [7:0] in_byte;
    logic       busy;
    logic       done;
    logic       match;
    logic [4:0] mismatch_cnt;
    logic [7:0] first_mis_addr;

    int n_vec = 0;
    int n_mis = 0;

    face_rom dut (
        .clk            (clk),
        .rst            (rst),
        .addr           (addr),
        .data           (data),
        .start          (start),
        .in_valid       (in_valid),
        .in_byte        (in_byte),
        .busy           (busy),
        .done           (done),
        .match          (match),
        .mismatch_cnt   (mismatch_cnt),
        .first_mis_addr (first_mis_addr)
    );

    always #5 if (clk_en) clk = ~clk;

    typedef struct {
        logic [7:0] a;
        logic [7:0] exp;
    } rd_vec_t;

    typedef struct {
        logic [15:0] bad_mask;
        logic [7:0]  bad_byte;
        logic        gaps;
        logic        exp_match;
        logic [4:0]  exp_cnt;
        logic [7:0]  exp_first;
    } run_vec_t;

    rd_vec_t  rd_tab [6];
    run_vec_t run_tab [4];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_run(input run_vec_t r, input string tag);
        // start cycle also presents a bogus valid byte that must not be consumed
        @(negedge clk);
        start    = 1'b1;
        in_valid = 1'b1;
        in_byte  = 8'h00;
        @(negedge clk);
        start    = 1'b0;
        in_valid = 1'b0;
        chk({tag, " busy_run"}, busy, 1);
        for (int i = 0; i < 16; i++) begin
            if (r.gaps) begin
                in_valid = 1'b0;
                start    = 1'b1;
                @(negedge clk);
                start = 1'b0;
                chk({tag, " gap_nodone"}, done, 0);
            end
            in_valid = 1'b1;
            in_byte  = r.bad_mask[i] ? r.bad_byte : 8'h74;
            if (i > 0) chk({tag, " early_done"}, done, 0);
            @(negedge clk);
        end
        in_valid = 1'b0;
        chk({tag, " done"}, done, 1);
        chk({tag, " busy_fin"}, busy, 0);
        chk({tag, " match"}, match, r.exp_match);
        chk({tag, " cnt"}, mismatch_cnt, r.exp_cnt);
        chk({tag, " first"}, first_mis_addr, r.exp_first);
        @(negedge clk);
        chk({tag, " done_drop"}, done, 0);
        chk({tag, " match_hold"}, match, r.exp_match);
        chk({tag, " cnt_hold"}, mismatch_cnt, r.exp_cnt);
    endtask

    initial begin
        rd_tab[0] = '{8'h00, 8'h74};
        rd_tab[1] = '{8'h0F, 8'h74};
        rd_tab[2] = '{8'h10, 8'h4A};
        rd_tab[3] = '{8'h11, 8'h4B};
        rd_tab[4] = '{8'h80, 8'hDA};
        rd_tab[5] = '{8'hFF, 8'hA5};

        run_tab[0] = '{16'h0000, 8'h00, 1'b0, 1'b1, 5'd0, 8'd0};
        run_tab[1] = '{16'h0208, 8'h00, 1'b0, 1'b0, 5'd2, 8'd3};
        run_tab[2] = '{16'h0000, 8'h00, 1'b1, 1'b1, 5'd0, 8'd0};
        run_tab[3] = '{16'h8000, 8'hFF, 1'b0, 1'b0, 5'd1, 8'd15};

        rst      = 1'b1;
        start    = 1'b0;
        in_valid = 1'b0;
        in_byte  = 8'h00;
        addr     = 8'h00;

        // ROM reads with the clock stopped and reset held
        foreach (rd_tab[i]) begin
            addr = rd_tab[i].a;
            #1;
            chk($sformatf("rom_tab[%0h]", rd_tab[i].a), data, rd_tab[i].exp);
        end
        for (int a = 0; a < 256; a++) begin
            logic [7:0] e;
            e = (a < 16) ? 8'h74 : (8'(a) ^ 8'h5A);
            addr = 8'(a);
            #1;
            chk($sformatf("rom_sweep[%0h]", a), data, e);
        end

        clk_en = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_match", match, 0);
        chk("rst_cnt", mismatch_cnt, 0);
        chk("rst_first", first_mis_addr, 0);

        foreach (run_tab[i]) begin
            do_run(run_tab[i], $sformatf("run%0d", i));
        end

        // reset in the middle of a run aborts it without a done pulse
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            in_byte  = (i == 2) ? 8'h00 : 8'h74;
            @(negedge clk);
        end
        in_valid = 1'b0;
        chk("pre_abort_cnt", mismatch_cnt, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_cnt", mismatch_cnt, 0);
        chk("abort_first", first_mis_addr, 0);
        chk("abort_done", done, 0);
        for (int i = 0; i < 20; i++) begin
            in_valid = 1'b1;
            in_byte  = 8'h74;
            @(negedge clk);
            chk("abort_no_done", done, 0);
        end
        in_valid = 1'b0;

        do_run('{16'hFFFF, 8'h75, 1'b0, 1'b0, 5'd16, 8'd0}, "all_bad");

        // pixel port unaffected by an active run or reset
        addr = 8'h10;
        rst  = 1'b1;
        #1;
        chk("rom_in_rst", data, 8'h4A);
        rst = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
